mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus load-data alignment for the MIPS32 core.
- Captures the MEM-stage result and drives the GPR write port (write enable, address, data) one cycle later.
- Holds synchronous data-memory read data across WB stalls so the written value stays stable while the stage is frozen.

Parameters:
- DATA_W, 32, datapath and register width.
- ADDR_W, 5, GPR address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-low (rst==0 resets on the next posedge).
- stall_i  input  1  hold the WB register contents.
- flush_i  input  1  load a bubble into WB.
- mem_wen_i  input  1  MEM instruction writes a GPR.
- mem_waddr_i  input  ADDR_W  destination register.
- mem_wdata_i  input  DATA_W  ALU result for non-loads; old rt value for loads.
- mem_is_load_i  input  1  MEM instruction is a load.
- mem_load_op_i  input  3  load type (see Behaviour).
- mem_byte_off_i  input  2  effective address [1:0].
- mem_rdata_i  input  DATA_W  data-RAM read word; valid in the cycle the load sits in WB.
- rd_write_o  output  1  GPR write enable.
- rd_addr_o  output  ADDR_W  GPR write address.
- write_data_o  output  DATA_W  GPR write data.
- wb_valid_o  output  1  WB holds a real instruction (not a bubble).

Behaviour:
- Reset (rst==0 at posedge): valid_q=0, wen_q=0, addr_q=0, data_q=0, is_load_q=0, op_q=0, off_q=0, rdata_q=0, first_q=0. All outputs read 0 the cycle after.
- Register update priority at posedge:
  - rst==0 first.
  - flush_i next: bubble, valid_q=0, wen_q=0. Flush wins over stall.
  - stall_i next: hold everything.
  - Otherwise capture all mem_* inputs; valid_q=1; first_q=mem_is_load_i.
- Latency: one cycle from mem_* inputs to the rd_* outputs; the GPR commits at the following edge.
- rd_write_o = valid_q & wen_q & (addr_q != 0). rd_addr_o = addr_q. wb_valid_o = valid_q.
- write_data_o:
  - Non-load: data_q.
  - Load: align(op_q, off_q, src, data_q), where src = mem_rdata_i if first_q, else rdata_q.
- Read-data hold: at a posedge with stall_i=1 and first_q=1, set rdata_q <= mem_rdata_i and clear first_q. Later stalled cycles use rdata_q, so the output stays stable while mem_rdata_i changes.
- During a stall the write repeats every cycle; this is idempotent.
- Load ops (big-endian, byte 0 = bits 31:24):
  - 000 LW: whole word.
  - 001 LB: selected byte, sign-extended.
  - 010 LBU: selected byte, zero-extended.
  - 011 LH: half chosen by off[1] (0 = bits 31:16), sign-extended.
  - 100 LHU: as LH, zero-extended.
  - 101 LWL.
  - 110 LWR.
  - 111: treated as LW.
- off[0] is ignored for halfwords; alignment exceptions are raised upstream.
- LWL, by off 0..3: mem; {mem[23:0],rt[7:0]}; {mem[15:0],rt[15:0]}; {mem[7:0],rt[23:0]}.
- LWR, by off 0..3: {rt[31:8],mem[31:24]}; {rt[31:16],mem[31:16]}; {rt[31:24],mem[31:8]}; mem.

Optional Feature:
- MEM_WB_UNALIGNED_EN defined: LWL/LWR merge with the old rt value (data_q) as specified above.
- Undefined: op codes 101/110 decode as LW, and the rt-merge logic is removed.

Decomposition:
- define.v holds:
  - the load-op codes (LOAD_LW, LOAD_LB, LOAD_LBU, LOAD_LH, LOAD_LHU, LOAD_LWL, LOAD_LWR);
  - the existing RegBuss / RegAddrBuss widths.
- One combinational sub-module, load_align: inputs op, off, mem word, rt; output aligned word.
- mem_wb_stage instantiates load_align and owns all registers.

Test Plan:
- Reset: hold rst=0 for 2 cycles with mem_wen_i=1 -> rd_write_o=0, write_data_o=0, wb_valid_o=0.
- ALU write: mem_waddr_i=5, mem_wdata_i=0x1234_5678, not a load -> next cycle rd_write_o=1, rd_addr_o=5, write_data_o=0x12345678. Same with addr 0 -> rd_write_o=0.
- Byte/half loads, mem_rdata_i=0x80F1_7F02:
  - LB off1 -> 0xFFFFFFF1.
  - LBU off1 -> 0x000000F1.
  - LH off0 -> 0xFFFF80F1.
  - LHU off2 -> 0x00007F02.
- Stall hold: LW enters WB with mem_rdata_i=0xAAAA_0001, then stall 3 cycles while mem_rdata_i changes to 0xDEAD_BEEF -> write_data_o stays 0xAAAA0001 throughout.
- Flush vs stall: stall_i=1 and flush_i=1 together -> next cycle wb_valid_o=0, rd_write_o=0.
- With MEM_WB_UNALIGNED_EN, rt=0x1122_3344, mem=0xAABB_CCDD:
  - LWL off2 -> 0xCCDD3344.
  - LWR off1 -> 0x1122AABB.
  - Without the macro, LWL off2 -> 0xAABBCCDD.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_pkg
// Shared definitions for the MEM/WB stage of the MIPS32 core:
//   - GPR bus widths (RegBuss / RegAddrBuss equivalents)
//   - load-op encodings driven by the decoder down to writeback
// Optional feature macro used by the importing files: MEM_WB_UNALIGNED_EN
// -----------------------------------------------------------------------------
package mem_wb_stage_pkg;

    localparam int REG_BUS_W      = 32;  // RegBuss
    localparam int REG_ADDR_BUS_W = 5;   // RegAddrBuss

    typedef logic [2:0] load_op_t;

    localparam load_op_t LOAD_LW  = 3'b000;
    localparam load_op_t LOAD_LB  = 3'b001;
    localparam load_op_t LOAD_LBU = 3'b010;
    localparam load_op_t LOAD_LH  = 3'b011;
    localparam load_op_t LOAD_LHU = 3'b100;
    localparam load_op_t LOAD_LWL = 3'b101;
    localparam load_op_t LOAD_LWR = 3'b110;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Purely combinational big-endian load alignment (byte 0 = bits 31:24).
// Ports:
//   i_op    load type (LOAD_* codes, 3'b111 behaves as LW)
//   i_off   effective address [1:0]; bit 0 ignored for halfwords
//   i_mem   data-RAM read word
//   i_rt    old rt value, merged by LWL/LWR (only with MEM_WB_UNALIGNED_EN)
//   o_data  aligned value for the GPR
// Macro: MEM_WB_UNALIGNED_EN enables LWL/LWR merging; without it those codes
// decode as LW and the rt input does not exist.
// -----------------------------------------------------------------------------
module load_align
    import mem_wb_stage_pkg::*;
(
    input  load_op_t               i_op,
    input  logic [1:0]             i_off,
    input  logic [REG_BUS_W-1:0]   i_mem,
`ifdef MEM_WB_UNALIGNED_EN
    input  logic [REG_BUS_W-1:0]   i_rt,
`endif
    output logic [REG_BUS_W-1:0]   o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_byte = i_mem[31:24];
        case (i_off)
            2'd0: w_byte = i_mem[31:24];
            2'd1: w_byte = i_mem[23:16];
            2'd2: w_byte = i_mem[15:8];
            2'd3: w_byte = i_mem[7:0];
            default: w_byte = i_mem[31:24];
        endcase
        w_half = i_off[1] ? i_mem[15:0] : i_mem[31:16];
    end

    always_comb begin
        o_data = i_mem;
        case (i_op)
            LOAD_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            LOAD_LBU: o_data = {24'h0, w_byte};
            LOAD_LH:  o_data = {{16{w_half[15]}}, w_half};
            LOAD_LHU: o_data = {16'h0, w_half};
`ifdef MEM_WB_UNALIGNED_EN
            // LWL fills from the MSB end, keeping the low rt bytes.
            LOAD_LWL: begin
                case (i_off)
                    2'd0: o_data = i_mem;
                    2'd1: o_data = {i_mem[23:0], i_rt[7:0]};
                    2'd2: o_data = {i_mem[15:0], i_rt[15:0]};
                    2'd3: o_data = {i_mem[7:0],  i_rt[23:0]};
                    default: o_data = i_mem;
                endcase
            end
            // LWR fills from the LSB end, keeping the high rt bytes.
            LOAD_LWR: begin
                case (i_off)
                    2'd0: o_data = {i_rt[31:8],  i_mem[31:24]};
                    2'd1: o_data = {i_rt[31:16], i_mem[31:16]};
                    2'd2: o_data = {i_rt[31:24], i_mem[31:8]};
                    2'd3: o_data = i_mem;
                    default: o_data = i_mem;
                endcase
            end
`endif
            default:  o_data = i_mem;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// MEM/WB pipeline register with load-data alignment. Drives the GPR write
// port one cycle after the MEM-stage inputs are captured, and freezes the
// synchronous RAM read word on the first stalled cycle so the written value
// stays stable while mem_rdata_i moves on.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-low reset
//   stall_i, flush_i  hold WB / insert bubble (flush wins)
//   mem_*_i           MEM-stage write enable, address, data, load info
//   mem_rdata_i       data-RAM word, valid while the load sits in WB
//   rd_write_o, rd_addr_o, write_data_o   GPR write port
//   wb_valid_o        WB holds a real instruction
// Macro: MEM_WB_UNALIGNED_EN enables LWL/LWR rt merging in load_align.
// -----------------------------------------------------------------------------
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              mem_wen_i,
    input  logic [ADDR_W-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              mem_is_load_i,
    input  load_op_t          mem_load_op_i,
    input  logic [1:0]        mem_byte_off_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rd_write_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] write_data_o,
    output logic              wb_valid_o
);

    logic              r_valid;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_is_load;
    load_op_t          r_op;
    logic [1:0]        r_off;
    logic [DATA_W-1:0] r_rdata;
    logic              r_first;   // RAM word still live on mem_rdata_i

    logic [DATA_W-1:0] w_src;
    logic [DATA_W-1:0] w_aligned;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_wen     <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_is_load <= 1'b0;
            r_op      <= LOAD_LW;
            r_off     <= 2'd0;
            r_rdata   <= '0;
            r_first   <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_wen   <= 1'b0;
        end else if (stall_i) begin
            // The RAM only presents the word for one cycle; park it on the
            // first stalled edge and read the copy from then on.
            if (r_first) begin
                r_rdata <= mem_rdata_i;
                r_first <= 1'b0;
            end
        end else begin
            r_valid   <= 1'b1;
            r_wen     <= mem_wen_i;
            r_addr    <= mem_waddr_i;
            r_data    <= mem_wdata_i;
            r_is_load <= mem_is_load_i;
            r_op      <= mem_load_op_i;
            r_off     <= mem_byte_off_i;
            r_first   <= mem_is_load_i;
        end
    end

    assign w_src = r_first ? mem_rdata_i : r_rdata;

    load_align u_load_align (
        .i_op   (r_op),
        .i_off  (r_off),
        .i_mem  (w_src),
`ifdef MEM_WB_UNALIGNED_EN
        .i_rt   (r_data),
`endif
        .o_data (w_aligned)
    );

    // r0 is hardwired to zero, so writes to it are suppressed here.
    assign rd_write_o   = r_valid & r_wen & (r_addr != '0);
    assign rd_addr_o    = r_addr;
    assign write_data_o = r_is_load ? w_aligned : r_data;
    assign wb_valid_o   = r_valid;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
// Scoreboard bench for mem_wb_stage: each issued instruction pushes its
// expected GPR-port values; they are popped and compared when the instruction
// is in WB. Expected LWL/LWR results follow MEM_WB_UNALIGNED_EN.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic        mem_wen_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_is_load_i;
    load_op_t    mem_load_op_i;
    logic [1:0]  mem_byte_off_i;
    logic [31:0] mem_rdata_i;
    logic        rd_write_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] write_data_o;
    logic        wb_valid_o;

    mem_wb_stage u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .mem_wen_i      (mem_wen_i),
        .mem_waddr_i    (mem_waddr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_is_load_i  (mem_is_load_i),
        .mem_load_op_i  (mem_load_op_i),
        .mem_byte_off_i (mem_byte_off_i),
        .mem_rdata_i    (mem_rdata_i),
        .rd_write_o     (rd_write_o),
        .rd_addr_o      (rd_addr_o),
        .write_data_o   (write_data_o),
        .wb_valid_o     (wb_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        valid;
        logic        chk_data;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data, input logic valid, input logic chk_data);
        exp_t e;
        e.we = we; e.addr = addr; e.data = data; e.valid = valid; e.chk_data = chk_data;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    // Compare the oldest scoreboard entry against the GPR port right now.
    task automatic compare_next();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            check({t, "_valid"}, {31'd0, wb_valid_o}, {31'd0, e.valid});
            check({t, "_we"},    {31'd0, rd_write_o}, {31'd0, e.we});
            if (e.valid)    check({t, "_addr"}, {27'd0, rd_addr_o}, {27'd0, e.addr});
            if (e.chk_data) check({t, "_data"}, write_data_o, e.data);
        end
    endtask

    // Drive one instruction into MEM, present its RAM word while it is in WB,
    // then compare at the following negedge.
    task automatic issue(input string tag, input logic wen, input logic [4:0] addr,
                         input logic [31:0] wdata, input logic is_load, input load_op_t op,
                         input logic [1:0] off, input logic [31:0] rdata,
                         input logic exp_we, input logic [31:0] exp_data);
        @(negedge clk);
        stall_i = 1'b0; flush_i = 1'b0;
        mem_wen_i = wen; mem_waddr_i = addr; mem_wdata_i = wdata;
        mem_is_load_i = is_load; mem_load_op_i = op; mem_byte_off_i = off;
        push_exp(tag, exp_we, addr, exp_data, 1'b1, 1'b1);
        @(posedge clk); #1;
        mem_rdata_i = rdata;
        mem_wen_i = 1'b0; mem_is_load_i = 1'b0; mem_wdata_i = 32'h0; mem_waddr_i = 5'd0;
        @(negedge clk);
        compare_next();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        mem_wen_i = 1'b1; mem_waddr_i = 5'd7; mem_wdata_i = 32'hCAFE_F00D;
        mem_is_load_i = 1'b0; mem_load_op_i = LOAD_LW; mem_byte_off_i = 2'd0;
        mem_rdata_i = 32'h0;

        // Reset held for two edges with a writing instruction on the inputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_we",    {31'd0, rd_write_o}, 32'd0);
        check("reset_data",  write_data_o,        32'd0);
        check("reset_valid", {31'd0, wb_valid_o}, 32'd0);
        check("reset_addr",  {27'd0, rd_addr_o},  32'd0);
        rst = 1'b1;
        mem_wen_i = 1'b0;

        // ALU results.
        issue("alu_r5", 1'b1, 5'd5, 32'h1234_5678, 1'b0, LOAD_LW, 2'd0, 32'h0, 1'b1, 32'h1234_5678);
        issue("alu_r0", 1'b1, 5'd0, 32'h1234_5678, 1'b0, LOAD_LW, 2'd0, 32'h0, 1'b0, 32'h1234_5678);
        issue("alu_nowen", 1'b0, 5'd9, 32'h0BAD_0001, 1'b0, LOAD_LW, 2'd0, 32'h0, 1'b0, 32'h0BAD_0001);

        // Byte / halfword loads from 0x80F1_7F02.
        issue("lb_off1",  1'b1, 5'd3, 32'h0, 1'b1, LOAD_LB,  2'd1, 32'h80F1_7F02, 1'b1, 32'hFFFF_FFF1);
        issue("lbu_off1", 1'b1, 5'd3, 32'h0, 1'b1, LOAD_LBU, 2'd1, 32'h80F1_7F02, 1'b1, 32'h0000_00F1);
        issue("lb_off3",  1'b1, 5'd3, 32'h0, 1'b1, LOAD_LB,  2'd3, 32'h80F1_7F02, 1'b1, 32'h0000_0002);
        issue("lh_off0",  1'b1, 5'd4, 32'h0, 1'b1, LOAD_LH,  2'd0, 32'h80F1_7F02, 1'b1, 32'hFFFF_80F1);
        issue("lhu_off2", 1'b1, 5'd4, 32'h0, 1'b1, LOAD_LHU, 2'd2, 32'h80F1_7F02, 1'b1, 32'h0000_7F02);
        issue("lh_off3",  1'b1, 5'd4, 32'h0, 1'b1, LOAD_LH,  2'd3, 32'h80F1_7F02, 1'b1, 32'h0000_7F02);
        issue("lw",       1'b1, 5'd6, 32'h0, 1'b1, LOAD_LW,  2'd0, 32'h80F1_7F02, 1'b1, 32'h80F1_7F02);
        issue("op111",    1'b1, 5'd6, 32'h0, 1'b1, 3'b111,   2'd1, 32'h80F1_7F02, 1'b1, 32'h80F1_7F02);

        // Unaligned loads, rt = 0x1122_3344, mem = 0xAABB_CCDD.
`ifdef MEM_WB_UNALIGNED_EN
        issue("lwl_off2", 1'b1, 5'd8, 32'h1122_3344, 1'b1, LOAD_LWL, 2'd2, 32'hAABB_CCDD, 1'b1, 32'hCCDD_3344);
        issue("lwr_off1", 1'b1, 5'd8, 32'h1122_3344, 1'b1, LOAD_LWR, 2'd1, 32'hAABB_CCDD, 1'b1, 32'h1122_AABB);
        issue("lwl_off1", 1'b1, 5'd8, 32'h1122_3344, 1'b1, LOAD_LWL, 2'd1, 32'hAABB_CCDD, 1'b1, 32'hBBCC_DD44);
        issue("lwr_off3", 1'b1, 5'd8, 32'h1122_3344, 1'b1, LOAD_LWR, 2'd3, 32'hAABB_CCDD, 1'b1, 32'hAABB_CCDD);
`else
        issue("lwl_off2", 1'b1, 5'd8, 32'h1122_3344, 1'b1, LOAD_LWL, 2'd2, 32'hAABB_CCDD, 1'b1, 32'hAABB_CCDD);
        issue("lwr_off1", 1'b1, 5'd8, 32'h1122_3344, 1'b1, LOAD_LWR, 2'd1, 32'hAABB_CCDD, 1'b1, 32'hAABB_CCDD);
`endif

        // Stall hold: LW in WB, RAM word changes while stalled three cycles.
        @(negedge clk);
        mem_wen_i = 1'b1; mem_waddr_i = 5'd9; mem_wdata_i = 32'h0;
        mem_is_load_i = 1'b1; mem_load_op_i = LOAD_LW; mem_byte_off_i = 2'd0;
        push_exp("stall_c0", 1'b1, 5'd9, 32'hAAAA_0001, 1'b1, 1'b1);
        @(posedge clk); #1;
        mem_rdata_i = 32'hAAAA_0001;
        mem_wen_i = 1'b0; mem_is_load_i = 1'b0; mem_waddr_i = 5'd0;
        stall_i = 1'b1;
        @(negedge clk);
        compare_next();
        for (int i = 1; i <= 3; i++) begin
            push_exp($sformatf("stall_c%0d", i), 1'b1, 5'd9, 32'hAAAA_0001, 1'b1, 1'b1);
            @(posedge clk); #1;
            mem_rdata_i = 32'hDEAD_BEEF;
            @(negedge clk);
            compare_next();
        end

        // Flush together with stall: bubble wins.
        flush_i = 1'b1;
        push_exp("flush_stall", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        flush_i = 1'b0; stall_i = 1'b0;
        @(negedge clk);
        compare_next();

        // Pipeline resumes normally after the bubble.
        issue("after_flush", 1'b1, 5'd31, 32'h5A5A_A5A5, 1'b0, LOAD_LW, 2'd0, 32'h0, 1'b1, 32'h5A5A_A5A5);

        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
